// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline register: state encoding,
// reset/bubble constants and the link-address helper.
package if_id_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_LOADED = 2'd1,
      ST_HOLD   = 2'd2
   } ifid_state_e;

   localparam logic [31:0] IFID_NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] IFID_RESET_PC = 32'h0000_3000;

   // Link address for jal/jalr; the 32-bit result wraps naturally.
   function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
      return pc + 32'd8;
   endfunction

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall hold, flush-to-bubble and deferred flush.
// Optional performance counters are enabled by defining IFID_PERF_EN.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFID_RESET_PC,
   parameter logic [31:0] NOP_WORD = IFID_NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc8,
   output logic        id_valid,
`ifdef IFID_PERF_EN
   output logic [31:0] perf_valid_cnt,
   output logic [31:0] perf_bubble_cnt,
`endif
   output logic        id_held
);

   ifid_state_e state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        pending_flush_q, pending_flush_d;

`ifdef IFID_PERF_EN
   logic [31:0] perf_valid_cnt_q, perf_valid_cnt_d;
   logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;
`endif

   // Next-state and next-contents selection: stall > flush (new or pending) > load.
   always_comb begin
      state_d         = state_q;
      instr_d         = instr_q;
      pc_d            = pc_q;
      pending_flush_d = pending_flush_q;

      if (stall) begin
         // A flush seen under stall is remembered, not applied.
         pending_flush_d = pending_flush_q | flush;
         case (state_q)
            ST_EMPTY:  state_d = ST_EMPTY;
            ST_LOADED: state_d = ST_HOLD;
            ST_HOLD:   state_d = ST_HOLD;
            default:   state_d = ST_EMPTY;
         endcase
      end else if (flush || pending_flush_q) begin
         state_d         = ST_EMPTY;
         instr_d         = NOP_WORD;
         pc_d            = if_pc;
         pending_flush_d = 1'b0;
      end else begin
         state_d         = ST_LOADED;
         instr_d         = if_instr;
         pc_d            = if_pc;
         pending_flush_d = 1'b0;
      end
   end

`ifdef IFID_PERF_EN
   // Counter increments: delivered instructions and bubble/stall cycles.
   always_comb begin
      perf_valid_cnt_d  = perf_valid_cnt_q;
      perf_bubble_cnt_d = perf_bubble_cnt_q;
      if ((state_q == ST_LOADED) && !stall) begin
         perf_valid_cnt_d = perf_valid_cnt_q + 32'd1;
      end else begin
         perf_valid_cnt_d = perf_valid_cnt_q;
      end
      if (stall || (state_q == ST_EMPTY)) begin
         perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
      end else begin
         perf_bubble_cnt_d = perf_bubble_cnt_q;
      end
   end
`endif

   // Pipeline register; reset discards any hold and any pending flush at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= ST_EMPTY;
         instr_q           <= NOP_WORD;
         pc_q              <= RESET_PC;
         pending_flush_q   <= 1'b0;
`ifdef IFID_PERF_EN
         perf_valid_cnt_q  <= 32'd0;
         perf_bubble_cnt_q <= 32'd0;
`endif
      end else begin
         state_q           <= state_d;
         instr_q           <= instr_d;
         pc_q              <= pc_d;
         pending_flush_q   <= pending_flush_d;
`ifdef IFID_PERF_EN
         perf_valid_cnt_q  <= perf_valid_cnt_d;
         perf_bubble_cnt_q <= perf_bubble_cnt_d;
`endif
      end
   end

   assign id_instr = instr_q;
   assign id_pc    = pc_q;
   assign id_pc8   = pc_plus8(pc_q);
   assign id_valid = (state_q == ST_LOADED) || (state_q == ST_HOLD);
   assign id_held  = (state_q == ST_HOLD);

`ifdef IFID_PERF_EN
   assign perf_valid_cnt  = perf_valid_cnt_q;
   assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule
